multicycle_control_fsm: RTL and testbench

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

---
 rtl/multicycle_control_fsm.sv | 245 ++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//   Control unit for a multicycle RV32I-style datapath (optional MUL).
//   Sequences FETCH/DECODE and one of the execute paths. All datapath controls
//   are combinational in the current state, the instruction fields, zero and
//   mem_ready.
//
// Handshake: in FETCH, MEMRD and MEMWR the FSM holds mem_req (plus adr_src and,
//   for stores, mem_write) steady until the cycle mem_ready is high. That cycle
//   completes the access and the FSM advances on the next edge. mem_ready is
//   ignored in every other state.
//
// Ports
//   clk, reset (async, active-low)
//   opcode/funct3/funct7 : instruction fields, stable from DECODE onward
//   zero                 : ALU zero flag (branch resolution)
//   mem_ready            : memory completes the pending access this cycle
//   mem_req, mem_write, adr_src                 : memory interface controls
//   pc_write, ir_write, reg_write               : register load enables
//   result_src, alu_src_a, alu_src_b            : datapath mux selects
//   alu_control, imm_src                        : ALU op / immediate format
//   illegal                                     : sticky illegal-instruction flag
//   state                                       : current state code (debug)
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter bit          ENABLE_MUL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_control,
    output logic [2:0] imm_src,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXECR  = 4'd6,  S_EXECI  = 4'd7,
        S_EXECM   = 4'd8,  S_ALUWB  = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
        S_JALR    = 4'd12, S_LINK   = 4'd13, S_AUIPC  = 4'd14, S_ILLEGAL = 4'd15
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                           ALU_SUB = 4'b0011, ALU_SLL = 4'b0100, ALU_SRL = 4'b0101,
                           ALU_SLT = 4'b0110, ALU_MUL = 4'b0111;

    localparam logic [6:0] OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_R    = 7'h33,
                           OP_I    = 7'h13, OP_JAL   = 7'h6F, OP_JALR = 7'h67,
                           OP_BR   = 7'h63, OP_AUIPC = 7'h17;

    localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MUL = 7'b0000001;

    // Counter load value: EXECM lasts cnt+1 cycles, leaving on cnt == 0.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       illegal_q, illegal_d;

    // funct3 -> ALU op shared by R-type (funct7=0) and I-type.
    function automatic logic [3:0] f3_to_alu(input logic [2:0] f3);
        case (f3)
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    logic f3_legal;
    logic r_legal;
    assign f3_legal = (funct3 != 3'b011) && (funct3 != 3'b100);
    assign r_legal  = ((funct7 == F7_BASE) && f3_legal) ||
                      ((funct7 == F7_ALT) && (funct3 == 3'b000));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        illegal_d   = illegal_q;
        mem_req     = 1'b0;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        imm_src     = 3'b000;

        case (opcode)
            OP_STORE: imm_src = 3'b001;
            OP_BR:    imm_src = 3'b010;
            OP_JAL:   imm_src = 3'b011;
            OP_AUIPC: imm_src = 3'b100;
            default:  imm_src = 3'b000;
        endcase

        // While reset is held every strobe stays low, even though the state
        // register already reads FETCH.
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        alu_src_b  = 2'b10;
                        result_src = 2'b10;
                        state_d    = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_R: begin
                            if (funct7 == F7_MUL)
                                state_d = ENABLE_MUL ? S_EXECM : S_ILLEGAL;
                            else
                                state_d = r_legal ? S_EXECR : S_ILLEGAL;
                        end
                        OP_I:     state_d = f3_legal ? S_EXECI : S_ILLEGAL;
                        OP_JAL:   state_d = S_JUMP;
                        OP_JALR:  state_d = S_JALR;
                        OP_BR:    state_d = S_BRANCH;
                        OP_AUIPC: state_d = S_AUIPC;
                        default:  state_d = S_ILLEGAL;
                    endcase
                    if (state_d == S_EXECM)   cnt_d     = MUL_LOAD;
                    if (state_d == S_ILLEGAL) illegal_d = 1'b1;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    state_d   = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                end
                S_EXECR: begin
                    alu_src_a   = 2'b10;
                    alu_control = (funct7 == F7_ALT) ? ALU_SUB : f3_to_alu(funct3);
                    state_d     = S_ALUWB;
                end
                S_EXECI: begin
                    alu_src_a   = 2'b10;
                    alu_src_b   = 2'b01;
                    alu_control = f3_to_alu(funct3);
                    state_d     = S_ALUWB;
                end
                S_EXECM: begin
                    alu_src_a   = 2'b10;
                    alu_control = ALU_MUL;
                    if (cnt_q == 4'd0) state_d = S_ALUWB;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a   = 2'b10;
                    alu_control = ALU_SUB;
                    case (funct3)
                        3'b000:  pc_write = zero;
                        3'b001:  pc_write = ~zero;
                        default: pc_write = 1'b0;
                    endcase
                    state_d = S_FETCH;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    state_d  = S_LINK;
                end
                S_JALR: begin
                    alu_src_a  = 2'b10;
                    alu_src_b  = 2'b01;
                    result_src = 2'b10;
                    pc_write   = 1'b1;
                    state_d    = S_LINK;
                end
                S_LINK: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    state_d   = S_ALUWB;
                end
                S_AUIPC: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    state_d   = S_ALUWB;
                end
                default: state_d = S_ILLEGAL;   // ILLEGAL is terminal until reset
            endcase
        end
    end

    assign illegal = illegal_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// Directed bench for multicycle_control_fsm. A second instance with
// ENABLE_MUL=0 shares the inputs so MUL decoding can be contrasted.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;

  logic       mem_req, pc_write, ir_write, adr_src, mem_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_control, state;
  logic [2:0] imm_src;

  logic       n_mem_req, n_pc_write, n_ir_write, n_adr_src, n_mem_write, n_reg_write, n_illegal;
  logic [1:0] n_result_src, n_alu_src_a, n_alu_src_b;
  logic [3:0] n_alu_control, n_state;
  logic [2:0] n_imm_src;

  multicycle_control_fsm #(.MUL_CYCLES(4), .ENABLE_MUL(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .pc_write(pc_write),
    .ir_write(ir_write), .adr_src(adr_src), .mem_write(mem_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
    .illegal(illegal), .state(state)
  );

  multicycle_control_fsm #(.MUL_CYCLES(4), .ENABLE_MUL(1'b0)) dut_nomul (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(n_mem_req), .pc_write(n_pc_write),
    .ir_write(n_ir_write), .adr_src(n_adr_src), .mem_write(n_mem_write),
    .reg_write(n_reg_write), .result_src(n_result_src), .alu_src_a(n_alu_src_a),
    .alu_src_b(n_alu_src_b), .alu_control(n_alu_control), .imm_src(n_imm_src),
    .illegal(n_illegal), .state(n_state)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH (mem_ready=1) then DECODE; returns in the first post-decode state
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op; funct3 = f3; funct7 = f7; mem_ready = 1'b1;
    #1;
    chk("fetch_state", int'(state), 0);
    chk("fetch_ir_write", int'(ir_write), 1);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("decode_state", int'(state), 1);
    tick();
  endtask

  initial begin
    reset = 1'b0; opcode = 7'h00; funct3 = 3'b000; funct7 = 7'h00;
    zero = 1'b0; mem_ready = 1'b1;
    #3;
    chk("rst_state", int'(state), 0);
    chk("rst_mem_req", int'(mem_req), 0);
    chk("rst_ir_write", int'(ir_write), 0);
    chk("rst_illegal", int'(illegal), 0);
    tick();
    reset = 1'b1;
    #1;
    chk("post_rst_mem_req", int'(mem_req), 1);
    chk("post_rst_adr_src", int'(adr_src), 0);

    // ADD: 0,1,6,9,0
    issue(7'h33, 3'b000, 7'h00);
    chk("add_state", int'(state), 6);
    chk("add_alu", int'(alu_control), 2);
    chk("add_src_a", int'(alu_src_a), 2);
    chk("add_src_b", int'(alu_src_b), 0);
    chk("add_no_wr", int'(reg_write), 0);
    chk("add_nomul_state", int'(n_state), 6);
    tick();
    chk("add_wb_state", int'(state), 9);
    chk("add_wb_reg_write", int'(reg_write), 1);
    chk("add_wb_result_src", int'(result_src), 0);
    tick();
    chk("add_back_fetch", int'(state), 0);

    // FETCH wait, then LW with 3 wait cycles in MEMRD
    opcode = 7'h03; funct3 = 3'b010; mem_ready = 1'b0;
    #1;
    chk("fwait_ir_write", int'(ir_write), 0);
    chk("fwait_pc_write", int'(pc_write), 0);
    chk("fwait_mem_req", int'(mem_req), 1);
    tick();
    chk("fwait_state", int'(state), 0);
    issue(7'h03, 3'b010, 7'h00);
    chk("lw_memadr", int'(state), 2);
    chk("lw_src_a", int'(alu_src_a), 2);
    chk("lw_src_b", int'(alu_src_b), 1);
    chk("lw_imm_src", int'(imm_src), 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_memrd_wait", int'(state), 3);
      chk("lw_wait_mem_req", int'(mem_req), 1);
      chk("lw_wait_adr_src", int'(adr_src), 1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_memrd_last", int'(state), 3);
    chk("lw_last_mem_req", int'(mem_req), 1);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("lw_memwb", int'(state), 4);
    chk("lw_result_src", int'(result_src), 1);
    chk("lw_reg_write", int'(reg_write), 1);
    tick();
    chk("lw_back_fetch", int'(state), 0);

    // SW with one wait cycle
    issue(7'h23, 3'b010, 7'h00);
    chk("sw_imm_src", int'(imm_src), 1);
    tick();
    chk("sw_memwr", int'(state), 5);
    chk("sw_mem_write", int'(mem_write), 1);
    chk("sw_adr_src", int'(adr_src), 1);
    tick();
    chk("sw_memwr_hold", int'(state), 5);
    chk("sw_mem_write_hold", int'(mem_write), 1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("sw_back_fetch", int'(state), 0);

    // MUL: EXECM for exactly 4 cycles; ENABLE_MUL=0 instance goes ILLEGAL
    issue(7'h33, 3'b000, 7'h01);
    chk("nomul_state", int'(n_state), 15);
    chk("nomul_illegal", int'(n_illegal), 1);
    for (int i = 0; i < 4; i++) begin
      chk("mul_execm", int'(state), 8);
      chk("mul_alu", int'(alu_control), 7);
      tick();
    end
    chk("mul_aluwb", int'(state), 9);
    chk("nomul_held", int'(n_state), 15);
    chk("nomul_mem_req", int'(n_mem_req), 0);
    tick();

    // SUB and ORI
    issue(7'h33, 3'b000, 7'h20);
    chk("sub_alu", int'(alu_control), 3);
    tick(); tick();
    issue(7'h13, 3'b110, 7'h00);
    chk("ori_state", int'(state), 7);
    chk("ori_alu", int'(alu_control), 1);
    chk("ori_src_b", int'(alu_src_b), 1);
    tick(); tick();

    // branches
    zero = 1'b1;
    issue(7'h63, 3'b000, 7'h00);
    chk("beq_state", int'(state), 10);
    chk("beq_taken", int'(pc_write), 1);
    chk("beq_alu", int'(alu_control), 3);
    chk("beq_imm_src", int'(imm_src), 2);
    tick();
    issue(7'h63, 3'b001, 7'h00);
    chk("bne_zero1", int'(pc_write), 0);
    zero = 1'b0;
    #1;
    chk("bne_zero0", int'(pc_write), 1);
    tick();
    zero = 1'b1;
    issue(7'h63, 3'b100, 7'h00);
    chk("b100_no_write", int'(pc_write), 0);
    tick();
    zero = 1'b0;

    // JALR: 1,12,13,9
    issue(7'h67, 3'b000, 7'h00);
    chk("jalr_state", int'(state), 12);
    chk("jalr_pc_write", int'(pc_write), 1);
    chk("jalr_result_src", int'(result_src), 2);
    tick();
    chk("jalr_link", int'(state), 13);
    chk("link_src_a", int'(alu_src_a), 1);
    chk("link_src_b", int'(alu_src_b), 2);
    tick();
    chk("jalr_aluwb", int'(state), 9);
    tick();

    // JAL and AUIPC
    issue(7'h6F, 3'b000, 7'h00);
    chk("jal_state", int'(state), 11);
    chk("jal_pc_write", int'(pc_write), 1);
    chk("jal_imm_src", int'(imm_src), 3);
    tick();
    chk("jal_link", int'(state), 13);
    tick(); tick();
    issue(7'h17, 3'b000, 7'h00);
    chk("auipc_state", int'(state), 14);
    chk("auipc_imm_src", int'(imm_src), 4);
    chk("auipc_src_a", int'(alu_src_a), 1);
    tick();
    chk("auipc_aluwb", int'(state), 9);
    tick();

    // unknown opcode -> ILLEGAL held
    issue(7'h7F, 3'b000, 7'h00);
    chk("ill_state", int'(state), 15);
    chk("ill_flag", int'(illegal), 1);
    mem_ready = 1'b1;
    tick(); tick();
    chk("ill_held", int'(state), 15);
    chk("ill_no_mem_req", int'(mem_req), 0);
    chk("ill_no_ir_write", int'(ir_write), 0);
    reset = 1'b0;
    #1;
    chk("ill_rst_state", int'(state), 0);
    chk("ill_rst_flag", int'(illegal), 0);
    tick();
    reset = 1'b1;

    // reset in the middle of EXECM, no clock edge needed
    issue(7'h33, 3'b000, 7'h01);
    tick();
    chk("mid_mul_state", int'(state), 8);
    reset = 1'b0;
    #1;
    chk("mid_mul_rst_state", int'(state), 0);
    chk("mid_mul_rst_mem_req", int'(mem_req), 0);
    tick();
    reset = 1'b1;
    // counter must reload after reset
    issue(7'h33, 3'b000, 7'h01);
    for (int i = 0; i < 4; i++) begin
      chk("mul2_execm", int'(state), 8);
      tick();
    end
    chk("mul2_aluwb", int'(state), 9);
    tick();

    // illegal I-type funct3
    issue(7'h13, 3'b011, 7'h00);
    chk("ill_itype", int'(state), 15);
    chk("ill_itype_flag", int'(illegal), 1);
    reset = 1'b0;
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
